ser_operand_feeder: RTL and testbench

- Upstream stage of the serial adder datapath.
- Accepts two parallel WIDTH-bit operands through a valid/ready handshake and shifts them out LSB-first, one bit per clock, onto the adder's serial A/B inputs.
- Emits first/last framing so the adder can clear its carry.
- Emits a one-cycle load strobe after the last bit so the downstream sum register captures the result.

---
 rtl/ser_pkg.sv | 18 +
 rtl/piso_shift.sv | 30 +++
 rtl/ser_operand_feeder.sv | 142 ++++++++++++++
 tb/tb_ser_operand_feeder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared constants and FSM encoding for the serial adder datapath
package ser_pkg;

    // Default operand width shared by the feeder, serial adder and sum collector
    localparam int SER_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2
    } ser_state_t;

    // Bit-counter width for a given operand width, never narrower than one bit
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// rtl/piso_shift.sv - parallel-load, shift-right, zero-fill register presenting its LSB
module piso_shift
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_lsb
);

    logic [WIDTH-1:0] r_data;

    // Load wins over shift; zero fill leaves the register empty once a word has drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= r_data >> 1;
        end
    end

    assign o_lsb = r_data[0];

endmodule

// File: rtl/ser_operand_feeder.sv
// rtl/ser_operand_feeder.sv - serialises operand pairs LSB-first with framing; optional SER_FEEDER_SUB_EN adds subtraction
module ser_operand_feeder
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef SER_FEEDER_SUB_EN
    input  logic             op_sub,
    output logic             cin_ser,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             a_ser,
    output logic             b_ser,
    output logic             ser_first,
    output logic             ser_last,
    output logic             ser_active,
    output logic             load_out
);

    localparam int               CNT_W        = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX     = CNT_W'(WIDTH - 1);
    // Only consulted when WIDTH >= 2; for WIDTH = 1 the SHIFT state always exits first
    localparam logic [CNT_W-1:0] PRE_LAST_IDX = CNT_W'(WIDTH - 2);

    ser_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_active;
    logic             r_first;
    logic             r_last;
    logic             r_load;

    logic             w_accept;
    logic             w_shift;
    logic [WIDTH-1:0] w_b_load;

    // Operands are only sampled on the edge that hands the pair over
    assign w_accept = (r_state == ST_IDLE) && r_in_ready && in_valid;
    assign w_shift  = (r_state == ST_SHIFT);

`ifdef SER_FEEDER_SUB_EN
    logic r_cin;
    // Subtraction streams ~B and injects the +1 through the carry-in on bit 0
    assign w_b_load = op_sub ? ~b_in : b_in;
    assign cin_ser  = r_cin;
`else
    assign w_b_load = b_in;
`endif

    piso_shift #(.WIDTH(WIDTH)) u_shift_a (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_data  (a_in),
        .o_lsb   (a_ser)
    );

    piso_shift #(.WIDTH(WIDTH)) u_shift_b (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_data  (w_b_load),
        .o_lsb   (b_ser)
    );

    // Sequencer: accept a pair, frame WIDTH serial bits, then one load strobe cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_active   <= 1'b0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
            r_load     <= 1'b0;
`ifdef SER_FEEDER_SUB_EN
            r_cin      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_load <= 1'b0;
                    if (w_accept) begin
                        r_state    <= ST_SHIFT;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_active   <= 1'b1;
                        r_first    <= 1'b1;
                        r_last     <= (WIDTH == 1);
`ifdef SER_FEEDER_SUB_EN
                        r_cin      <= op_sub;
`endif
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_first <= 1'b0;
`ifdef SER_FEEDER_SUB_EN
                    r_cin   <= 1'b0;
`endif
                    if (r_cnt == LAST_IDX) begin
                        r_state  <= ST_FLUSH;
                        r_active <= 1'b0;
                        r_last   <= 1'b0;
                        r_load   <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                        r_last <= (r_cnt == PRE_LAST_IDX);
                    end
                end
                ST_FLUSH: begin
                    r_state    <= ST_IDLE;
                    r_load     <= 1'b0;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_active   <= 1'b0;
                    r_first    <= 1'b0;
                    r_last     <= 1'b0;
                    r_load     <= 1'b0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign ser_active = r_active;
    assign ser_first  = r_first;
    assign ser_last   = r_last;
    assign load_out   = r_load;

endmodule

// File: tb/tb_ser_operand_feeder.sv
// tb/tb_ser_operand_feeder.sv - self-checking bench for ser_operand_feeder
module tb_ser_operand_feeder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         op_sub;
    logic         in_ready, a_ser, b_ser, ser_first, ser_last, ser_active, load_out;
    logic         cin_w;

    logic         in_valid1;
    logic [0:0]   a_in1, b_in1;
    logic         op_sub1;
    logic         in_ready1, a_ser1, b_ser1, first1, last1, active1, load1;

`ifdef SER_FEEDER_SUB_EN
    logic cin_ser, cin_ser1;
    assign cin_w = cin_ser;
`else
    assign cin_w = 1'b0;
`endif

    ser_operand_feeder #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
`ifdef SER_FEEDER_SUB_EN
        .op_sub     (op_sub),
        .cin_ser    (cin_ser),
`endif
        .a_in       (a_in),
        .b_in       (b_in),
        .a_ser      (a_ser),
        .b_ser      (b_ser),
        .ser_first  (ser_first),
        .ser_last   (ser_last),
        .ser_active (ser_active),
        .load_out   (load_out)
    );

    ser_operand_feeder #(.WIDTH(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
`ifdef SER_FEEDER_SUB_EN
        .op_sub     (op_sub1),
        .cin_ser    (cin_ser1),
`endif
        .a_in       (a_in1),
        .b_in       (b_in1),
        .a_ser      (a_ser1),
        .b_ser      (b_ser1),
        .ser_first  (first1),
        .ser_last   (last1),
        .ser_active (active1),
        .load_out   (load1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic ready;
        logic active;
        logic a;
        logic b;
        logic first;
        logic last;
        logic load;
        logic cin;
    } obs_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] seq_a;   // expected serial stream, leftmost digit = first cycle
        logic [W-1:0] seq_b;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    obs_t q[$];
    obs_t act;
    logic m_sub = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0b expected %0b", name, cyc, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.ready  = in_ready;
        o.active = ser_active;
        o.a      = a_ser;
        o.b      = b_ser;
        o.first  = ser_first;
        o.last   = ser_last;
        o.load   = load_out;
        o.cin    = cin_w;
        return o;
    endfunction

    // Reference: an accepted pair becomes WIDTH serial-bit cycles followed by one load cycle
    task automatic push_frame(input logic [W-1:0] av, input logic [W-1:0] bv);
        obs_t         o;
        logic [W-1:0] bb;
        bb = m_sub ? ~bv : bv;
        for (int i = 0; i < W; i++) begin
            o        = '0;
            o.active = 1'b1;
            o.a      = av[i];
            o.b      = bb[i];
            o.first  = (i == 0);
            o.last   = (i == W - 1);
            o.cin    = m_sub && (i == 0);
            q.push_back(o);
        end
        o      = '0;
        o.load = 1'b1;
        q.push_back(o);
    endtask

    // One clock: check this cycle's outputs against the model, then drive the next inputs
    task automatic cycle(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv, input logic r);
        obs_t e;
        @(negedge clk);
        cyc++;
        act = sample();
        if (rst) begin
            e = '0;
        end else if (q.size() > 0) begin
            e = q.pop_front();
        end else begin
            e       = '0;
            e.ready = 1'b1;
        end
        chk("cycle_outputs", 32'(act), 32'(e));
        rst      = r;
        in_valid = v;
        a_in     = av;
        b_in     = bv;
        op_sub   = m_sub;
        if (r) q.delete();
        else if (e.ready && v) push_frame(av, bv);
    endtask

    vec_t vecs[5];
    int   firsts[$];

    initial begin
        rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; op_sub = 1'b0;
        in_valid1 = 1'b0; a_in1 = '0; b_in1 = '0; op_sub1 = 1'b0;

        vecs[0] = '{4'b0101, 4'b0011, 4'b1010, 4'b1100};
        vecs[1] = '{4'b1001, 4'b0110, 4'b1001, 4'b0110};
        vecs[2] = '{4'b0011, 4'b1100, 4'b1100, 4'b0011};
        vecs[3] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};
        vecs[4] = '{4'b1000, 4'b0001, 4'b0001, 4'b1000};

        // Reset and release
        cycle(1'b0, '0, '0, 1'b1);
        chk("reset_ready", act.ready, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        chk("post_reset_ready", act.ready, 1'b1);
        chk("post_reset_active", act.active, 1'b0);

        // Table-driven single transfers
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, vecs[k].a, vecs[k].b, 1'b0);
            for (int i = 0; i < W; i++) begin
                cycle(1'b0, '0, '0, 1'b0);
                chk("tbl_a_ser", act.a, vecs[k].seq_a[W-1-i]);
                chk("tbl_b_ser", act.b, vecs[k].seq_b[W-1-i]);
            end
            cycle(1'b0, '0, '0, 1'b0);
            chk("tbl_load", act.load, 1'b1);
        end

        // Busy rejection: a changed operand held on in_valid is taken only after FLUSH
        cycle(1'b1, 4'b0101, 4'b0011, 1'b0);
        for (int i = 0; i < W; i++) begin
            cycle(1'b1, 4'b1111, 4'b0011, 1'b0);
            chk("busy_a_ser", act.a, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        cycle(1'b1, 4'b1111, 4'b0011, 1'b0);
        chk("busy_flush_load", act.load, 1'b1);
        cycle(1'b1, 4'b1111, 4'b0011, 1'b0);
        chk("busy_ready_again", act.ready, 1'b1);
        for (int i = 0; i < W; i++) begin
            cycle(1'b0, '0, '0, 1'b0);
            chk("held_a_ser", act.a, 1'b1);
        end
        cycle(1'b0, '0, '0, 1'b0);

        // Back-to-back with in_valid held high
        cycle(1'b1, 4'd9, 4'd6, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            cycle(i <= 6, 4'd3, 4'd12, 1'b0);
            if (act.first) firsts.push_back(cyc);
        end
        chk("b2b_frames", firsts.size(), 2);
        if (firsts.size() == 2) chk("b2b_spacing", firsts[1] - firsts[0], W + 2);

        // Reset during serial bit 2
        cycle(1'b1, 4'b0110, 4'b1010, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1);
        chk("mid_bit2_active", act.active, 1'b1);
        #1;
        chk("async_reset_zero", 32'(sample()), 32'd0);
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b1, 4'b0011, 4'b0101, 1'b0);
        chk("restart_ready", act.ready, 1'b1);
        cycle(1'b0, '0, '0, 1'b0);
        chk("restart_first", act.first, 1'b1);
        for (int i = 0; i < W + 1; i++) cycle(1'b0, '0, '0, 1'b0);

`ifdef SER_FEEDER_SUB_EN
        // Subtraction: B streamed inverted, carry-in on bit 0 only
        m_sub = 1'b1;
        cycle(1'b1, 4'b0110, 4'b0010, 1'b0);
        m_sub = 1'b0;
        for (int i = 0; i < W; i++) begin
            cycle(1'b0, '0, '0, 1'b0);
            chk("sub_b_ser", act.b, (i == 1) ? 1'b0 : 1'b1);
            chk("sub_cin", act.cin, (i == 0) ? 1'b1 : 1'b0);
        end
        cycle(1'b0, '0, '0, 1'b0);
`endif

        // Randomised traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            m_sub = 1'b0;
`ifdef SER_FEEDER_SUB_EN
            m_sub = 1'($urandom_range(0, 1));
`endif
            cycle(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), ($urandom_range(0, 63) == 0));
        end
        m_sub = 1'b0;
        for (int i = 0; i < W + 3; i++) cycle(1'b0, '0, '0, 1'b0);

        // WIDTH=1 instance: first and last coincide in the single serial cycle
        @(negedge clk);
        chk("w1_ready", in_ready1, 1'b1);
        in_valid1 = 1'b1; a_in1 = 1'b1; b_in1 = 1'b0;
        @(negedge clk);
        in_valid1 = 1'b0; a_in1 = 1'b0;
        chk("w1_frame", {active1, first1, last1, a_ser1, b_ser1}, 5'b11110);
        @(negedge clk);
        chk("w1_load", {load1, active1, in_ready1}, 3'b100);
        @(negedge clk);
        chk("w1_ready_back", {load1, in_ready1}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
